// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle datapath and a word-wide data RAM.
// Byte-addressed sub-word accesses become word accesses; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  signExt,
  input  logic [ADDR_WIDTH+1:0] byteAddr,
  input  logic [31:0]           wData,
  output logic [31:0]           rData,
  output logic                  busy,
  output logic                  done,
  output logic                  misaligned,
  output logic                  ramWrite,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [31:0]           ramInData,
  input  logic [31:0]           ramOutData
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Size 11 is never legal; halves need an even offset, words a zero offset.
  function automatic logic align_fault(input logic [1:0] sz, input logic [1:0] off);
    logic f;
    f = 1'b0;
    case (sz)
      2'b00:   f = 1'b0;
      2'b01:   f = off[0];
      2'b10:   f = (off != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // Selects the little-endian lane addressed by off and widens it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] off, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = off[1] ? word[31:16] : word[15:0];
    r = 32'h0000_0000;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    case (sz)
      2'b00:   r = {{24{sext & b[7]}}, b};
      2'b01:   r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replaces the addressed lane(s) of word with the low bits of data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (sz)
      2'b00: begin
        case (off)
          2'b00:   r[7:0]   = data[7:0];
          2'b01:   r[15:8]  = data[7:0];
          2'b10:   r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          r[31:16] = data[15:0];
        end else begin
          r[15:0] = data[15:0];
        end
      end
      default: r = data;
    endcase
    return r;
  endfunction

  state_t                state_r;
  state_t                next_state_s;
  logic                  we_r;
  logic [1:0]            size_r;
  logic                  sext_r;
  logic [31:0]           wdata_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [1:0]            off_r;
  logic [31:0]           merge_r;
  logic [31:0]           rdata_r;
  logic                  done_r;
  logic                  misaligned_r;
  logic                  fault_s;
  logic                  accept_s;
  logic                  ram_write_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [31:0]           ram_in_s;

  assign fault_s  = align_fault(size, byteAddr[1:0]);
  assign accept_s = (state_r == ST_IDLE) && req;

  // Next-state selection; requests are only looked at in IDLE.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (!req) begin
          next_state_s = ST_IDLE;
        end else if (fault_s) begin
          next_state_s = ST_DONE;
        end else if (!we) begin
          next_state_s = ST_LOAD;
        end else if (size == 2'b10) begin
          next_state_s = ST_WRITE;
        end else begin
          next_state_s = ST_RMW_RD;
        end
      end
      ST_LOAD:   next_state_s = ST_DONE;
      ST_RMW_RD: next_state_s = ST_WRITE;
      ST_WRITE:  next_state_s = ST_DONE;
      ST_DONE:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request latch, captured only at the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sext_r  <= 1'b0;
      wdata_r <= 32'h0000_0000;
      waddr_r <= {ADDR_WIDTH{1'b0}};
      off_r   <= 2'b00;
    end else if (accept_s) begin
      we_r    <= we;
      size_r  <= size;
      sext_r  <= signExt;
      wdata_r <= wData;
      waddr_r <= byteAddr[ADDR_WIDTH+1:2];
      off_r   <= byteAddr[1:0];
    end
  end

  // Load result and read-modify-write merge word, both taken from the combinational RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= 32'h0000_0000;
      merge_r <= 32'h0000_0000;
    end else begin
      if (state_r == ST_LOAD) begin
        rdata_r <= extract_lane(ramOutData, size_r, off_r, sext_r);
      end
      if (state_r == ST_RMW_RD) begin
        merge_r <= merge_lane(ramOutData, wdata_r, size_r, off_r);
      end
    end
  end

  // Completion pulses are registered so they line up exactly with the DONE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r       <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      done_r       <= (next_state_s == ST_DONE);
      misaligned_r <= accept_s && fault_s;
    end
  end

  // RAM port drive; the write strobe is gated by reset so an aborted store never lands.
  always_comb begin
    ram_write_s = 1'b0;
    ram_addr_s  = waddr_r;
    ram_in_s    = 32'h0000_0000;
    case (state_r)
      ST_IDLE: ram_addr_s = byteAddr[ADDR_WIDTH+1:2];
      ST_WRITE: begin
        ram_write_s = ~reset;
        ram_in_s    = (size_r == 2'b10) ? wdata_r : merge_r;
      end
      default: ram_addr_s = waddr_r;
    endcase
  end

  assign busy       = (state_r != ST_IDLE);
  assign done       = done_r;
  assign misaligned = misaligned_r;
  assign rData      = rdata_r;
  assign ramWrite   = ram_write_s;
  assign ramAddr    = ram_addr_s;
  assign ramInData  = ram_in_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a word-array reference model predicts each completion,
// a monitor pops predictions whenever done is seen and compares result, fault flag and latency.
module tb_mem_access_unit;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          signExt = 1'b0;
  logic [AW+1:0] byteAddr = '0;
  logic [31:0]   wData = 32'h0;
  logic [31:0]   rData;
  logic          busy, done, misaligned, ramWrite;
  logic [AW-1:0] ramAddr;
  logic [31:0]   ramInData, ramOutData;
  logic          ram_clear = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .signExt(signExt),
    .byteAddr(byteAddr), .wData(wData), .rData(rData), .busy(busy), .done(done),
    .misaligned(misaligned), .ramWrite(ramWrite), .ramAddr(ramAddr),
    .ramInData(ramInData), .ramOutData(ramOutData)
  );

  // Data RAM: synchronous write, combinational read.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'h0;
    end else if (ramWrite) begin
      ram[ramAddr] <= ramInData;
    end
  end
  assign ramOutData = ram[ramAddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    int          lat;
    bit          mis;
    logic [31:0] rdata;
    int          writes;
    logic [AW-1:0] waddr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_mem [0:(1<<AW)-1];
  logic [31:0] last_rdata = 32'h0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-word array updated with shifts and masks.
  task automatic model_op(input bit w, input bit [1:0] sz, input bit sx, input bit [AW+1:0] a,
                          input bit [31:0] d, input int acc);
    exp_t        e;
    int          wi, sh;
    logic [31:0] word, v, mask;
    bit          fault;
    wi    = int'(a >> 2);
    sh    = 8 * int'(a % 4);
    word  = model_mem[wi];
    fault = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    e.acc = acc;
    e.waddr = AW'(wi);
    e.mis = fault;
    e.writes = 0;
    if (fault) begin
      e.lat = 1;
    end else if (!w) begin
      e.lat = 2;
      if (sz == 2'd0) begin
        v = (word >> sh) & 32'hFF;
        if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = (word >> sh) & 32'hFFFF;
        if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = word;
      end
      last_rdata = v;
    end else begin
      e.writes = 1;
      if (sz == 2'd2) begin
        e.lat = 2;
        model_mem[wi] = d;
      end else begin
        e.lat = 3;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        model_mem[wi] = (word & ~mask) | ((d << sh) & mask);
      end
    end
    e.rdata = last_rdata;
    q.push_back(e);
  endtask

  // Monitor: sample well after the edge, pop a prediction on every done.
  int wr_seen = 0;
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() == 0) begin
      chk("idle_ramwrite", {31'b0, ramWrite}, 32'h0);
      chk("spurious_done", {31'b0, done}, 32'h0);
    end else begin
      if (ramWrite) begin
        chk("write_addr", {22'b0, ramAddr}, {22'b0, q[0].waddr});
        wr_seen++;
      end
      if (done) begin
        e = q.pop_front();
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
        chk("rdata", rData, e.rdata);
        chk("write_count", 32'(wr_seen), 32'(e.writes));
        wr_seen = 0;
      end else begin
        chk("misaligned_without_done", {31'b0, misaligned}, 32'h0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("wait_idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic drive(input bit w, input bit [1:0] sz, input bit sx, input bit [AW+1:0] a,
                       input bit [31:0] d);
    we = w; size = sz; signExt = sx; byteAddr = a; wData = d; req = 1'b1;
  endtask

  task automatic issue(input bit w, input bit [1:0] sz, input bit sx, input bit [AW+1:0] a,
                       input bit [31:0] d);
    wait_idle();
    drive(w, sz, sx, a, d);
    @(posedge clk); #1;
    model_op(w, sz, sx, a, d, cyc);
    req = 1'b0;
  endtask

  // Starts an access and asserts reset one cycle after acceptance.
  task automatic abort_op(input bit w, input bit [1:0] sz, input bit [AW+1:0] a, input bit [31:0] d);
    wait_idle();
    drive(w, sz, 1'b0, a, d);
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b1;
    #1;
    chk("ramwrite_under_reset", {31'b0, ramWrite}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_rdata = 32'h0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_rdata", rData, 32'h0);
  endtask

  initial begin
    int n, mm;
    bit [AW+1:0] a;
    bit [1:0] sz;
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ram_clear = 1'b0;
    chk("reset_rdata", rData, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_misaligned", {31'b0, misaligned}, 32'h0);

    issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 12'h022, 32'h000000AA);
    issue(1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 12'h030, 32'h8000F0FF);
    issue(1'b0, 2'd0, 1'b1, 12'h030, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 12'h030, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 12'h032, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 12'h030, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 12'h021, 32'h0000BEEF);
    issue(1'b0, 2'd2, 1'b0, 12'h012, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 12'h030, 32'h12345678);
    issue(1'b0, 2'd2, 1'b0, 12'h020, 32'h0);

    abort_op(1'b1, 2'd1, 12'h040, 32'h0000BEEF);
    abort_op(1'b1, 2'd2, 12'h044, 32'h12345678);
    issue(1'b0, 2'd2, 1'b0, 12'h040, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 12'h044, 32'h0);

    // req held high: second acceptance only once back in IDLE.
    wait_idle();
    drive(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    @(posedge clk); #1;
    model_op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, cyc);
    repeat (3) begin @(posedge clk); #1; end
    model_op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, cyc);
    req = 1'b0;

    for (int k = 0; k < 250; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = (AW+2)'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'h0);
    mm = 0;
    for (int i = 0; i < (1 << AW); i++) if (ram[i] !== model_mem[i]) mm++;
    chk("mem_image", 32'(mm), 32'h0);
    chk("final_rdata", rData, last_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
